// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the execute stage and seq_alu.
//   start/op/a/b       : request, driven by the master (execute stage)
//   busy/done          : handshake status, driven by the ALU
//   result/zf/nf/cf/vf : registered result and condition flags, valid with done
//   illegal            : unassigned opcode indication, valid with done
interface seq_alu_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             nf;
  logic             cf;
  logic             vf;
  logic             illegal;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zf, nf, cf, vf, illegal
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zf, nf, cf, vf, illegal
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with Z/N/C/V flags, illegal-op flag and an iterative
// shift-add multiplier (one multiplier bit per cycle).
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : seq_alu_if.slave -- start/op/a/b in; busy/done/result/flags out
// Single-cycle ops raise done the cycle after acceptance. MUL holds busy for
// WIDTH cycles and raises done together with busy falling.
module seq_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_SRL  = 4'b0011,
    OP_SRA  = 4'b0100,
    OP_NAND = 4'b0101,
    OP_OR   = 4'b0110,
    OP_MUL  = 4'b1000,
    OP_AND  = 4'b1001,
    OP_XOR  = 4'b1010
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             state;
  logic [WIDTH-1:0]   result_q;
  logic               zf_q, nf_q, cf_q, vf_q, ill_q, busy_q, done_q;

  // multiplier datapath: acc = {partial product, remaining multiplier bits}
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     psum;
  logic [CW-1:0]      cnt;

  // single-cycle datapath
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cf, alu_vf, alu_ill;
  logic [WIDTH:0]     add_w, sub_w, sll_w, shr_w, sra_w;
  logic [SHW-1:0]     amt;
  logic               sat;

  assign amt = bus.b[SHW-1:0];
  assign sat = |(bus.b >> SHW);

  always_comb begin
    add_w = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w = {1'b0, bus.a} - {1'b0, bus.b};
    // one guard bit on the exit side captures the last bit shifted out
    sll_w = {1'b0, bus.a} << amt;
    shr_w = {bus.a, 1'b0} >> amt;
    sra_w = $signed({bus.a, 1'b0}) >>> amt;

    alu_res = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    alu_ill = 1'b0;
    case (op_e'(bus.op))
      OP_ADD: begin
        alu_res = add_w[MSB:0];
        alu_cf  = add_w[WIDTH];
        alu_vf  = (bus.a[MSB] == bus.b[MSB]) && (add_w[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_w[MSB:0];
        alu_cf  = sub_w[WIDTH];
        alu_vf  = (bus.a[MSB] != bus.b[MSB]) && (sub_w[MSB] != bus.a[MSB]);
      end
      OP_SLL: if (!sat) begin
        alu_res = sll_w[MSB:0];
        alu_cf  = sll_w[WIDTH];
      end
      OP_SRL: if (!sat) begin
        alu_res = shr_w[WIDTH:1];
        alu_cf  = shr_w[0];
      end
      OP_SRA: begin
        if (sat) begin
          alu_res = {WIDTH{bus.a[MSB]}};
        end else begin
          alu_res = sra_w[WIDTH:1];
          alu_cf  = sra_w[0];
        end
      end
      OP_NAND: alu_res = ~(bus.a & bus.b);
      OP_OR:   alu_res = bus.a | bus.b;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {psum, acc[MSB:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      result_q <= '0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      cf_q     <= 1'b0;
      vf_q     <= 1'b0;
      ill_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      cnt      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (op_e'(bus.op) == OP_MUL) begin
              state  <= S_MUL;
              busy_q <= 1'b1;
              acc    <= {{WIDTH{1'b0}}, bus.b};
              mcand  <= bus.a;
              cnt    <= '0;
            end else begin
              done_q   <= 1'b1;
              result_q <= alu_res;
              zf_q     <= (alu_res == '0);
              nf_q     <= alu_res[MSB];
              cf_q     <= alu_cf;
              vf_q     <= alu_vf;
              ill_q    <= alu_ill;
            end
          end
        end
        S_MUL: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= acc_next[MSB:0];
            zf_q     <= (acc_next[MSB:0] == '0);
            nf_q     <= acc_next[MSB];
            cf_q     <= |acc_next[2*WIDTH-1:WIDTH];
            vf_q     <= 1'b0;
            ill_q    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.result  = result_q;
  assign bus.zf      = zf_q;
  assign bus.nf      = nf_q;
  assign bus.cf      = cf_q;
  assign bus.vf      = vf_q;
  assign bus.illegal = ill_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the combinational 16-bit datapath ALU.
- Generalises operand width and adds full condition flags (Z/N/C/V), an illegal-op indication and an iterative shift-add multiplier.
- Uses a start/busy/done handshake so the execute stage can stall on multi-cycle ops.
- Sits between the register-file read ports and the writeback mux of the RISC core.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of two)
SHW, $clog2(WIDTH), number of shift-amount bits examined before saturation

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; op/a/b sampled on the edge where start=1 and busy=0
op  input  4  operation select
a  input  WIDTH  operand A
b  input  WIDTH  operand B (shift amount for shifts)
busy  output  1  high while a MUL is iterating; start is ignored while high
done  output  1  one-cycle pulse: result/flags valid and updated
result  output  WIDTH  registered result; held until next done
zf  output  1  result == 0
nf  output  1  result[WIDTH-1]
cf  output  1  carry/borrow/shift-out/mul-overflow
vf  output  1  signed overflow
illegal  output  1  op was unassigned; valid with done

Behaviour:
- Reset (async, any time, including mid-MUL):
  - result=0; zf=nf=cf=vf=illegal=0; busy=0; done=0.
  - FSM returns to IDLE and any MUL in progress is aborted.
- Op encoding:
  - 0000 ADD; 0001 SUB; 0010 SLL; 0011 SRL; 0100 SRA; 0101 NAND; 0110 OR; 1000 MUL; 1001 AND; 1010 XOR.
  - All other codes are illegal.
- Operands are latched at acceptance; later changes on a/b/op have no effect on the accepted operation.
- FSM states:
  - IDLE: accept start. Single-cycle op -> done=1 next cycle, stay IDLE. MUL -> MUL state, busy=1.
  - MUL: WIDTH iterations of shift-add (one multiplier bit per cycle), accumulator 2*WIDTH bits. After the last iteration -> IDLE with busy=0 and done=1 in the same cycle.
- Latency:
  - Single-cycle ops: done is high in the cycle after the accepting edge.
  - MUL: busy is high for exactly WIDTH cycles; done is asserted WIDTH+1 cycles after the accepting edge.
- Throughput:
  - start held high in IDLE with single-cycle ops -> one done every cycle.
  - start in the same cycle done is high (busy=0) is accepted.
  - start while busy=1 is dropped, not queued.
- done is a single-cycle pulse; result and flags hold their values until the next done.
- Arithmetic rules:
  - ADD/SUB are modulo 2^WIDTH.
  - ADD: cf = carry out.
  - SUB: cf = borrow (a < b unsigned).
  - ADD/SUB: vf = two's-complement overflow.
- Shift rules, with amount = b as unsigned:
  - amount >= WIDTH saturates: SLL/SRL give 0, SRA gives WIDTH copies of a[WIDTH-1]; cf=0.
  - Otherwise cf = last bit shifted out (0 when amount=0).
  - vf=0 for all shifts.
- MUL: unsigned; result = low WIDTH bits of the product; cf = (high WIDTH bits != 0); vf=0.
- Logic ops (NAND/OR/AND/XOR): cf=vf=0.
- zf and nf are always derived from the registered result.
- Illegal op: single-cycle; result=0, zf=1, nf=cf=vf=0, illegal=1.
- illegal is cleared on the next done of a legal op.

Test Plan:
1. ADD a=0x7FFF b=0x0001, start 1 cycle -> next cycle done=1, result=0x8000, nf=1, vf=1, cf=0, zf=0.
2. SUB a=0x0003 b=0x0005 -> result=0xFFFE, cf=1, nf=1, vf=0. Then SRA a=0x8008 b=3 -> result=0xF001, cf=0. Then SLL a=0x8008 b=20 -> result=0x0000, zf=1, cf=0.
3. MUL a=0x0100 b=0x0100 -> busy high exactly 16 cycles, done 17 cycles after accept, result=0x0000, zf=1, cf=1. A second start (ADD) issued during busy is ignored: no extra done, result unchanged.
4. Back-to-back: start held high for 4 cycles with ADDs 1+1, 2+2, 3+3, 4+4 -> done high for 4 consecutive cycles with results 2, 4, 6, 8.
5. Reset mid-MUL: MUL 0x1234*0x0003, assert rst at cycle 5 of busy -> busy, done and result go to 0 immediately. After release, ADD 5+6 -> result=0x000B, done after 1 cycle.
6. Illegal op=0111 -> done=1, illegal=1, result=0, zf=1. Next OR a=0x00F0 b=0x000F -> result=0x00FF, illegal=0.
